// File: rtl/inst_fetch_unit.sv
// HISOC instruction fetch front end: owns the PC, issues word reads to the
// synchronous instruction memory and hands {pc, inst} pairs to decode.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MEM_AW   = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  output logic              imem_en,
  output logic [MEM_AW-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              if_valid,
  output logic [31:0]       if_pc,
  output logic [31:0]       if_inst,
  input  logic              if_ready
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_ent_t;

  logic [31:0] fetch_pc;
  logic [31:0] inflight_pc;
  logic        inflight;
  logic        kill;
  logic [1:0]  count;
  logic [2:0]  occ;
  logic        pop;
  logic        push;
  logic        issue;
  fetch_ent_t  ent0;
  fetch_ent_t  ent1;
  fetch_ent_t  ret;

  assign if_valid = (count != 2'd0);
  assign if_pc    = ent0.pc;
  assign if_inst  = ent0.inst;

  assign pop  = if_valid && if_ready;
  // a redirect always lands on the cycle the stale read returns
  assign kill = redirect_valid;
  assign push = inflight && !kill;
  assign ret  = '{pc: inflight_pc, inst: imem_rdata};

  assign occ = {1'b0, count}
             + {2'b00, inflight}
             - {2'b00, pop};

  assign issue = !rst && enable
              && !redirect_valid
              && (occ < 3'd2);

  assign imem_en   = issue;
  assign imem_addr = fetch_pc[MEM_AW+1:2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight_pc <= '0;
      inflight    <= 1'b0;
      count       <= 2'd0;
      ent0        <= '0;
      ent1        <= '0;
    end else begin
      inflight <= issue;
      if (issue)
        inflight_pc <= fetch_pc;

      if (redirect_valid)
        fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
      else if (issue)
        fetch_pc <= fetch_pc + 32'd4;

      if (redirect_valid) begin
        count <= 2'd0;
      end else begin
        // ent0 is the head; ent1 only ever holds the second entry
        unique case (1'b1)
          push && pop: begin
            if (count == 2'd2) begin
              ent0 <= ent1;
              ent1 <= ret;
            end else begin
              ent0 <= ret;
            end
          end
          pop && !push: begin
            ent0  <= ent1;
            count <= count - 2'd1;
          end
          push && !pop: begin
            if (count == 2'd0)
              ent0 <= ret;
            else
              ent1 <= ret;
            count <= count + 2'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: stream, backpressure, redirects,
// PC wrap and asynchronous reset, against a 1-cycle memory model.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_ready;
  logic        imem_en;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  logic        rst_w;
  logic        enable_w;
  logic        imem_en_w;
  logic [9:0]  imem_addr_w;
  logic [31:0] imem_rdata_w;
  logic        if_valid_w;
  logic [31:0] if_pc_w;
  logic [31:0] if_inst_w;

  int   n_chk = 0;
  int   n_err = 0;
  logic en_seen;

  always #5 clk = ~clk;

  inst_fetch_unit #(.RESET_PC(32'h0), .MEM_AW(10)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_pc(if_pc),
    .if_inst(if_inst), .if_ready(if_ready)
  );

  inst_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .MEM_AW(10)) dut_w (
    .clk(clk), .rst(rst_w), .enable(enable_w),
    .imem_en(imem_en_w), .imem_addr(imem_addr_w),
    .imem_rdata(imem_rdata_w),
    .redirect_valid(1'b0),
    .redirect_pc(32'h0),
    .if_valid(if_valid_w), .if_pc(if_pc_w),
    .if_inst(if_inst_w), .if_ready(1'b1)
  );

  always @(posedge clk) begin
    if (imem_en)
      imem_rdata <= 32'h1000_0000 + {22'd0, imem_addr};
    if (imem_en_w)
      imem_rdata_w <= 32'h1000_0000 + {22'd0, imem_addr_w};
  end

  function automatic logic [31:0] word(input logic [31:0] pc);
    return 32'h1000_0000 + {22'd0, pc[11:2]};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rst_w = 1'b1;
    enable = 1'b0; enable_w = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    if_ready = 1'b0; en_seen = 1'b0;

    repeat (2) cyc();
    @(negedge clk);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_en",    {31'd0, imem_en}, 32'd0);
    chk("rst_addr",  {22'd0, imem_addr}, 32'd0);
    chk("rst_pc",    if_pc, 32'd0);
    chk("rst_inst",  if_inst, 32'd0);
    chk("rstw_addr", {22'd0, imem_addr_w}, 32'h3FE);
    chk("rstw_valid", {31'd0, if_valid_w}, 32'd0);

    cyc();
    rst = 1'b0; rst_w = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      en_seen = en_seen | imem_en;
      cyc();
    end
    @(negedge clk);
    chk("idle_en",    {31'd0, en_seen}, 32'd0);
    chk("idle_valid", {31'd0, if_valid}, 32'd0);
    chk("idle_pc",    if_pc, 32'd0);
    chk("idle_addr",  {22'd0, imem_addr}, 32'd0);

    // stream: enable rises in cycle N
    cyc();
    enable = 1'b1; if_ready = 1'b1;
    @(negedge clk);
    chk("n0_en",   {31'd0, imem_en}, 32'd1);
    chk("n0_addr", {22'd0, imem_addr}, 32'd0);
    cyc();
    @(negedge clk);
    chk("n1_valid", {31'd0, if_valid}, 32'd0);
    for (int i = 0; i < 32; i++) begin
      cyc();
      @(negedge clk);
      chk("st_valid", {31'd0, if_valid}, 32'd1);
      chk("st_pc",    if_pc, 32'(4 * i));
      chk("st_inst",  if_inst, word(32'(4 * i)));
    end

    // backpressure: head 0x80 must hold with two entries buffered
    cyc();
    if_ready = 1'b0;
    for (int h = 0; h < 8; h++) begin
      @(negedge clk);
      chk("bp_valid", {31'd0, if_valid}, 32'd1);
      chk("bp_pc",    if_pc, 32'h80);
      chk("bp_inst",  if_inst, word(32'h80));
      chk("bp_en",    {31'd0, imem_en}, 32'd0);
      cyc();
    end
    if_ready = 1'b1;
    @(negedge clk);
    chk("rel_en",   {31'd0, imem_en}, 32'd1);
    chk("rel_addr", {22'd0, imem_addr}, 32'd34);
    chk("rel_pc",   if_pc, 32'h80);
    for (int j = 1; j < 6; j++) begin
      cyc();
      @(negedge clk);
      chk("rel_valid", {31'd0, if_valid}, 32'd1);
      chk("rel_seq",   if_pc, 32'h80 + 32'(4 * j));
      chk("rel_inst",  if_inst, word(32'h80 + 32'(4 * j)));
    end

    // redirect with an entry buffered and a read in flight
    cyc();
    if_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    @(negedge clk);
    chk("rd_en", {31'd0, imem_en}, 32'd0);
    chk("rd_pc", if_pc, 32'h98);
    cyc();
    redirect_valid = 1'b0; if_ready = 1'b1;
    @(negedge clk);
    chk("rd1_valid", {31'd0, if_valid}, 32'd0);
    chk("rd1_en",    {31'd0, imem_en}, 32'd1);
    chk("rd1_addr",  {22'd0, imem_addr}, 32'd16);
    cyc();
    @(negedge clk);
    chk("rd2_valid", {31'd0, if_valid}, 32'd0);
    cyc();
    @(negedge clk);
    chk("rd3_valid", {31'd0, if_valid}, 32'd1);
    chk("rd3_pc",    if_pc, 32'h40);
    chk("rd3_inst",  if_inst, 32'h1000_0010);
    cyc();
    @(negedge clk);
    chk("rd4_pc", if_pc, 32'h44);

    // redirect coinciding with a handshake of head 0x48
    cyc();
    redirect_valid = 1'b1; redirect_pc = 32'h43;
    @(negedge clk);
    chk("sr_valid", {31'd0, if_valid}, 32'd1);
    chk("sr_pc",    if_pc, 32'h48);
    cyc();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("sr1_valid", {31'd0, if_valid}, 32'd0);
    cyc();
    @(negedge clk);
    chk("sr2_valid", {31'd0, if_valid}, 32'd0);
    cyc();
    @(negedge clk);
    chk("sr3_valid", {31'd0, if_valid}, 32'd1);
    chk("sr3_pc",    if_pc, 32'h40);
    chk("sr3_inst",  if_inst, 32'h1000_0010);
    cyc();
    @(negedge clk);
    chk("sr4_pc", if_pc, 32'h44);
    cyc();
    enable = 1'b0;

    // PC wrap on the second instance
    enable_w = 1'b1;
    @(negedge clk);
    chk("w_en",   {31'd0, imem_en_w}, 32'd1);
    chk("w_addr", {22'd0, imem_addr_w}, 32'h3FE);
    cyc();
    @(negedge clk);
    chk("w1_valid", {31'd0, if_valid_w}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      @(negedge clk);
      chk("w_valid", {31'd0, if_valid_w}, 32'd1);
      chk("w_pc",    if_pc_w, 32'hFFFF_FFF8 + 32'(4 * k));
      chk("w_inst",  if_inst_w, word(32'hFFFF_FFF8 + 32'(4 * k)));
    end

    // asynchronous reset between clock edges
    #1;
    rst_w = 1'b1; enable_w = 1'b0;
    #1;
    chk("ar_valid", {31'd0, if_valid_w}, 32'd0);
    chk("ar_pc",    if_pc_w, 32'd0);
    chk("ar_en",    {31'd0, imem_en_w}, 32'd0);
    cyc();
    rst_w = 1'b0;
    for (int m = 0; m < 3; m++) begin
      @(negedge clk);
      chk("ar_hold_valid", {31'd0, if_valid_w}, 32'd0);
      chk("ar_hold_en",    {31'd0, imem_en_w}, 32'd0);
      chk("ar_hold_addr",  {22'd0, imem_addr_w}, 32'h3FE);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
